// File: rtl/run_detect_if.sv
// run_detect_if: groups the run detector's sample controls, sensor inputs and
// qualified outputs. The debug port y only exists when RUN_DETECT_DEBUG_EN is
// defined.
interface run_detect_if #(
  parameter int CH = 1
);
  logic          en;
  logic          clr;
  logic [CH-1:0] w;
  logic [CH-1:0] z;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
`ifdef RUN_DETECT_DEBUG_EN
  logic [2*CH-1:0] y;

  modport master (output en, output clr, output w,
                  input z, input rise, input fall, input y);
  modport slave  (input en, input clr, input w,
                  output z, output rise, output fall, output y);
`else
  modport master (output en, output clr, output w,
                  input z, input rise, input fall);
  modport slave  (input en, input clr, input w,
                  output z, output rise, output fall);
`endif
endinterface

// File: rtl/run_detect.sv
// run_detect: CH-channel Moore run detector with on/off hysteresis.
// A channel's z goes high after ON_LEN consecutive sampled 1s and low after
// OFF_LEN consecutive sampled 0s; rise/fall are registered one-cycle pulses.
// Optional feature: define RUN_DETECT_DEBUG_EN to export per-channel state
// codes on bus.y ({state[CH-1], ..., state[0]}).
module run_detect #(
  parameter int CH      = 1,
  parameter int ON_LEN  = 2,
  parameter int OFF_LEN = 1
) (
  input logic         clk,
  input logic         resetn,
  run_detect_if.slave bus
);
  localparam int MAX_LEN = (ON_LEN > OFF_LEN) ? ON_LEN : OFF_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] ON_CNT  = CNT_W'(ON_LEN);
  localparam logic [CNT_W-1:0] OFF_CNT = CNT_W'(OFF_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ARM    = 2'b01;
  localparam logic [1:0] ST_ACTIVE = 2'b10;
  localparam logic [1:0] ST_HOLD   = 2'b11;

  // Parameter legality is checked once at elaboration.
  if (CH < 1) begin : g_bad_ch
    $error("run_detect: CH must be >= 1");
  end
  if ((ON_LEN < 1) || (ON_LEN > 255)) begin : g_bad_on
    $error("run_detect: ON_LEN must be in 1..255");
  end
  if ((OFF_LEN < 1) || (OFF_LEN > 255)) begin : g_bad_off
    $error("run_detect: OFF_LEN must be in 1..255");
  end

  logic [CH-1:0][1:0]       state_q, state_d;
  logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CH-1:0]            rise_q, rise_d;
  logic [CH-1:0]            fall_q, fall_d;
  logic [CH-1:0]            z_s;

  // State register: per-channel state, run counter and event pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= '0;
      cnt_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic: clr beats en; en=0 freezes state and counters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < CH; i++) begin
      if (bus.clr) begin
        // Synchronous clear never produces a fall pulse.
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else if (bus.en) begin
        case (state_q[i])
          ST_IDLE: begin
            if (bus.w[i]) begin
              if (ON_LEN == 1) begin
                state_d[i] = ST_ACTIVE;
                cnt_d[i]   = '0;
                rise_d[i]  = 1'b1;
              end else begin
                state_d[i] = ST_ARM;
                cnt_d[i]   = CNT_ONE;
              end
            end else begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end
          end
          ST_ARM: begin
            if (bus.w[i]) begin
              if ((cnt_q[i] + CNT_ONE) == ON_CNT) begin
                state_d[i] = ST_ACTIVE;
                cnt_d[i]   = '0;
                rise_d[i]  = 1'b1;
              end else begin
                state_d[i] = ST_ARM;
                cnt_d[i]   = cnt_q[i] + CNT_ONE;
              end
            end else begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end
          end
          ST_ACTIVE: begin
            if (!bus.w[i]) begin
              if (OFF_LEN == 1) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
                fall_d[i]  = 1'b1;
              end else begin
                state_d[i] = ST_HOLD;
                cnt_d[i]   = CNT_ONE;
              end
            end else begin
              state_d[i] = ST_ACTIVE;
              cnt_d[i]   = '0;
            end
          end
          ST_HOLD: begin
            if (!bus.w[i]) begin
              if ((cnt_q[i] + CNT_ONE) == OFF_CNT) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
                fall_d[i]  = 1'b1;
              end else begin
                state_d[i] = ST_HOLD;
                cnt_d[i]   = cnt_q[i] + CNT_ONE;
              end
            end else begin
              // Bounce back to ACTIVE: z never dropped, so no rise pulse.
              state_d[i] = ST_ACTIVE;
              cnt_d[i]   = '0;
            end
          end
          default: begin
            // X or corrupted state recovers to IDLE.
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end else begin
        state_d[i] = state_q[i];
        cnt_d[i]   = cnt_q[i];
      end
    end
  end

  // Output decode: z depends on state only (Moore), never on w.
  always_comb begin
    z_s = '0;
    for (int i = 0; i < CH; i++) begin
      z_s[i] = (state_q[i] == ST_ACTIVE) || (state_q[i] == ST_HOLD);
    end
  end

  assign bus.z    = z_s;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

`ifdef RUN_DETECT_DEBUG_EN
  // The state register already is the registered state code.
  assign bus.y = state_q;
`endif

endmodule

// File: tb/tb_run_detect.sv
// tb_run_detect: directed-vector bench for run_detect with four parameter
// sets: (CH=1,2,1), (CH=1,4,3), (CH=3,2,1), (CH=1,1,1).
module tb_run_detect;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  run_detect_if #(.CH(1)) b0 ();
  run_detect_if #(.CH(1)) b1 ();
  run_detect_if #(.CH(3)) b2 ();
  run_detect_if #(.CH(1)) b3 ();

  run_detect #(.CH(1), .ON_LEN(2), .OFF_LEN(1)) u0 (.clk(clk), .resetn(resetn), .bus(b0));
  run_detect #(.CH(1), .ON_LEN(4), .OFF_LEN(3)) u1 (.clk(clk), .resetn(resetn), .bus(b1));
  run_detect #(.CH(3), .ON_LEN(2), .OFF_LEN(1)) u2 (.clk(clk), .resetn(resetn), .bus(b2));
  run_detect #(.CH(1), .ON_LEN(1), .OFF_LEN(1)) u3 (.clk(clk), .resetn(resetn), .bus(b3));

  // Expected values are {z, rise, fall} after each sampling edge.
  logic [4:0]  a_w = 5'b01110;               // bit i = w at step i: 0,1,1,1,0
  logic [2:0]  a_e [5] = '{3'b000, 3'b000, 3'b110, 3'b100, 3'b001};
  logic [11:0] b_w = 12'b0100_1111_0111;      // 1,1,1,0,1,1,1,1,0,0,1,0
  logic [2:0]  b_e [12] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                            3'b000, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0]  d_w [9] = '{3'b001, 3'b111, 3'b010, 3'b111, 3'b101,
                           3'b000, 3'b111, 3'b111, 3'b000};
  logic [8:0]  d_e [9] = '{9'b000_000_000, 9'b001_001_000, 9'b010_010_001,
                           9'b010_000_000, 9'b101_101_010, 9'b000_000_101,
                           9'b000_000_000, 9'b111_111_000, 9'b000_000_111};
  logic [3:0]  f_w = 4'b0101;                 // 1,0,1,0
  logic [2:0]  f_e [4] = '{3'b110, 3'b001, 3'b110, 3'b001};
  logic [1:0]  f_y [4] = '{2'b10, 2'b00, 2'b10, 2'b00};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".u0"}, 16'({b0.z, b0.rise, b0.fall}), 16'h0);
    check({tag, ".u1"}, 16'({b1.z, b1.rise, b1.fall}), 16'h0);
    check({tag, ".u2"}, 16'({b2.z, b2.rise, b2.fall}), 16'h0);
    check({tag, ".u3"}, 16'({b3.z, b3.rise, b3.fall}), 16'h0);
  endtask

  initial begin
    b0.en = 1'b0; b0.clr = 1'b0; b0.w = '0;
    b1.en = 1'b0; b1.clr = 1'b0; b1.w = '0;
    b2.en = 1'b0; b2.clr = 1'b0; b2.w = '0;
    b3.en = 1'b0; b3.clr = 1'b0; b3.w = '0;

    // Asynchronous reset, checked before any clock edge and after one.
    #1 resetn = 1'b0;
    #1 check_all_zero("rst_async");
    tick();
    check_all_zero("rst_clk");
    resetn = 1'b1;

    // A: default parameters, w = 0,1,1,1,0 then one more 0.
    b0.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b0.w = a_w[i];
      tick();
      check($sformatf("A%0d", i), 16'({b0.z, b0.rise, b0.fall}), 16'(a_e[i]));
    end
    b0.w = 1'b0;
    tick();
    check("A5", 16'({b0.z, b0.rise, b0.fall}), 16'h0);
    b0.en = 1'b0;

    // B: ON_LEN=4/OFF_LEN=3, aborted ARM, assert, HOLD and bounce back.
    b1.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b1.w = b_w[i];
      tick();
      check($sformatf("B%0d", i), 16'({b1.z, b1.rise, b1.fall}), 16'(b_e[i]));
    end
    // clr while in HOLD: z drops with no fall pulse.
    b1.clr = 1'b1;
    tick();
    check("B_clr", 16'({b1.z, b1.rise, b1.fall}), 16'h0);
    b1.clr = 1'b0;
    tick();
    check("B_clr_idle", 16'({b1.z, b1.rise, b1.fall}), 16'h0);

    // C: two 1s into ARM, freeze 5 cycles (w=0 would abort if not frozen).
    b1.w = 1'b1;
    tick();
    check("C_arm1", 16'({b1.z, b1.rise, b1.fall}), 16'h0);
    tick();
    check("C_arm2", 16'({b1.z, b1.rise, b1.fall}), 16'h0);
    b1.en = 1'b0;
    b1.w  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("C_frz%0d", i), 16'({b1.z, b1.rise, b1.fall}), 16'h0);
    end
    b1.en = 1'b1;
    b1.w  = 1'b1;
    tick();
    check("C_arm3", 16'({b1.z, b1.rise, b1.fall}), 16'h0);
    tick();
    check("C_assert", 16'({b1.z, b1.rise, b1.fall}), 16'b110);
    // en=0 after asserting: rise clears, z holds.
    b1.en = 1'b0;
    b1.w  = 1'b0;
    tick();
    check("C_hold_en0", 16'({b1.z, b1.rise, b1.fall}), 16'b100);

    // D: three channels with distinct, partly simultaneous events.
    b2.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      b2.w = d_w[i];
      tick();
      check($sformatf("D%0d", i), 16'({b2.z, b2.rise, b2.fall}), 16'(d_e[i]));
    end
    b2.en = 1'b0;

    // E: reset asserted between clock edges while u0 has just asserted.
    b0.en = 1'b1;
    b0.w  = 1'b1;
    tick();
    tick();
    check("E_pre", 16'({b0.z, b0.rise, b0.fall}), 16'b110);
    #2 resetn = 1'b0;
    #1 check_all_zero("E_rst");
    #1 resetn = 1'b1;
    // Partial state discarded: a single 1 only reaches ARM.
    tick();
    check("E_after", 16'({b0.z, b0.rise, b0.fall}), 16'h0);
    b0.en = 1'b0;

    // F: ON_LEN=OFF_LEN=1, w toggling every cycle.
    b3.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b3.w = f_w[i];
      tick();
      check($sformatf("F%0d", i), 16'({b3.z, b3.rise, b3.fall}), 16'(f_e[i]));
`ifdef RUN_DETECT_DEBUG_EN
      check($sformatf("F_y%0d", i), 16'(b3.y), 16'(f_y[i]));
`endif
    end
    b3.en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/run_detect.md
# run_detect

Parametrised multi-channel Moore run detector. Each of CH independent channels asserts its output after ON_LEN consecutive sampled 1s on its input and deasserts after OFF_LEN consecutive sampled 0s, giving built-in hysteresis. Registered one-cycle rise/fall event pulses are also provided. It sits between synchronised sensor inputs and control logic, where it qualifies raw levels into stable control flags.

## Interface
- CH, 1, number of independent channels
- ON_LEN, 2, consecutive 1 samples required to assert z (legal range 1..255)
- OFF_LEN, 1, consecutive 0 samples required to deassert z (legal range 1..255)
- CNT_W (localparam), clog2(max(ON_LEN,OFF_LEN)+1), width of the per-channel run counter
- clk  in  1  clock; all state changes on the rising edge
- resetn  in  1  reset, asynchronous, active-low
- en  in  1  synchronous sample enable; 0 freezes all channels
- clr  in  1  synchronous clear of all channels; takes priority over en
- w  in  CH  sensor inputs; must already be synchronous to clk
- z  out  CH  qualified level per channel (Moore output)
- rise  out  CH  one-cycle pulse on the first cycle z is high after an assertion
- fall  out  CH  one-cycle pulse on the first cycle z is low after a deassertion

## Operation
- Per-channel state is 2 bits: IDLE=00, ARM=01, ACTIVE=10, HOLD=11. Each channel also has a CNT_W-bit run counter cnt.
- On a sampling edge (en=1, clr=0), each channel transitions as follows:
  - IDLE, w=1: go to ACTIVE if ON_LEN==1; otherwise go to ARM with cnt=1.
  - IDLE, w=0: stay in IDLE.
  - ARM, w=1: if cnt+1==ON_LEN, go to ACTIVE with cnt=0; otherwise cnt++.
  - ARM, w=0: go to IDLE with cnt=0.
  - ACTIVE, w=0: go to IDLE if OFF_LEN==1; otherwise go to HOLD with cnt=1.
  - ACTIVE, w=1: stay in ACTIVE.
  - HOLD, w=0: if cnt+1==OFF_LEN, go to IDLE with cnt=0; otherwise cnt++.
  - HOLD, w=1: go to ACTIVE with cnt=0. No rise pulse is generated.
- z = (state==ACTIVE) or (state==HOLD). z is decoded from state only, never from w.
- rise is registered. It is 1 in the cycle after any edge that moves a channel from IDLE or ARM into ACTIVE.
- fall is registered. It is 1 in the cycle after any edge that moves a channel from ACTIVE or HOLD into IDLE.
- en=0 at an edge:
  - state and cnt hold.
  - rise and fall are 0 in the following cycle.
- clr=1 at an edge:
  - every channel goes to IDLE with cnt=0.
  - rise and fall are 0 in the following cycle. clr never generates a fall pulse.
- The counter never exceeds max(ON_LEN,OFF_LEN)-1, so no wrap-around can occur.
- Unreachable state encodings are not possible with 4 states in 2 bits. Any X on state recovers to IDLE.
- Parameters outside the legal range trigger a simulation $error at elaboration.

## Timing
- Reset (resetn=0, async): all channels IDLE, cnt=0; z=0, rise=0, fall=0 immediately, independent of clk.
- Reset release: the first sampling edge is the first rising clk edge with resetn=1.
- Assert latency: z rises in the cycle following the edge that samples the ON_LEN-th consecutive 1. rise is high in that same cycle.
- Deassert latency: z falls in the cycle following the edge that samples the OFF_LEN-th consecutive 0. fall is high in that same cycle.
- With default parameters (ON_LEN=2, OFF_LEN=1):
  - two consecutive sampled 1s put z high after the second edge;
  - a single sampled 0 drops z after that edge.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.
- Asserting resetn mid-run discards any partial count. Asserting clr mid-run does the same, but synchronously.

## Configuration
- RUN_DETECT_DEBUG_EN defined: adds output port y (out, 2*CH bits). Bits [2i+1:2i] carry channel i's current state code, registered and with the same reset value (00).
- RUN_DETECT_DEBUG_EN undefined: port y is absent. No debug logic is generated, and all other behaviour is identical.

## Test plan
- Default parameters, CH=1, w sequence 0,1,1,1,0: z = 0,0,0,1,1,0 (one cycle after each sample); rise=1 only in the first z=1 cycle; fall=1 in the cycle z returns to 0.
- ON_LEN=4, OFF_LEN=3, w sequence 1,1,1,0,1,1,1,1: ARM aborts at the 0 with no z; z rises only after the final four 1s; then w sequence 0,0,1 enters HOLD, returns to ACTIVE, and produces no rise or fall pulses.
- CH=3, w channels driven with distinct patterns in the same cycles: each z, rise and fall matches an independent single-channel model, with simultaneous pulses on all three channels.
- en=0 held for 5 cycles midway through an ARM run of 2 of 4 ones: the count is retained; after en returns to 1, two more 1s assert z.
- clr pulsed while z=1 in HOLD: z=0 next cycle, fall=0, state IDLE; resetn pulsed asynchronously between clock edges: all outputs go to 0 immediately.
- ON_LEN=1, OFF_LEN=1, w toggling every cycle: z follows w delayed by one cycle, with rise/fall on alternating cycles; with RUN_DETECT_DEBUG_EN defined, y alternates 10/00.
